shop_cmd_driver: RTL
====================

Name: shop_cmd_driver

Overview:
- Initiator side of the shop command interface: replays a loaded script of ASCII tokens into the shop FSM's i_rdy/i_a/i_u inputs and watches its o_a prompt/response word.
- Sits between a testbench or console loader and the shop block.
- Issues each token only after the shop shows a prompt, classifies the responses, counts errors and flags stalls.

Parameters:
- I_A_NUM_BITS, 56, token width (7 ASCII chars); must match shop input.
- O_A_NUM_BITS, 72, response width (9 ASCII chars); must match shop output.
- I_U_NUM_BITS, 4, numeric side-value width.
- SCRIPT_DEPTH, 16, script entries; power of 2.
- SETTLE_CYCLES, 4, maximum cycles to wait for o_a to change after an issue.
- TIMEOUT_CYCLES, 256, maximum cycles to wait for a prompt.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  async active-high reset.
- i_wr_en  in  1  script write strobe.
- i_wr_tok  in  I_A_NUM_BITS  token to append.
- i_wr_u  in  I_U_NUM_BITS  u value to append.
- o_full  out  1  script holds SCRIPT_DEPTH entries.
- i_start  in  1  single-cycle pulse; starts replay.
- i_shop_a  in  O_A_NUM_BITS  shop o_a.
- o_rdy  out  1  one-cycle token-valid pulse to the shop's i_rdy.
- o_a  out  I_A_NUM_BITS  token to the shop's i_a.
- o_u  out  I_U_NUM_BITS  value to the shop's i_u.
- o_busy  out  1  replay in progress.
- o_done  out  1  one-cycle pulse at replay end.
- o_timeout  out  1  sticky; last replay aborted by timeout.
- o_err_cnt  out  $clog2(SCRIPT_DEPTH+1)  error responses in the last replay.
- o_last_resp  out  O_A_NUM_BITS  most recent classified response.

Behaviour:
- Reset: all outputs 0; o_last_resp = 0; script count and read/write pointers 0; state IDLE.
- Prompt: i_shop_a[7:0] == "?" (0x3F).
- Success: i_shop_a is one of "UsrDeletd", "ItmAdded", "ItmDeletd", "ItmBought", compared as zero-left-padded ASCII.
- Error: any other non-prompt, non-zero word.
- Loading:
  - In IDLE, i_wr_en with count < SCRIPT_DEPTH stores {tok, u} at wptr and increments wptr/count.
  - Writes while full or not IDLE are dropped silently.
  - o_full is registered and updates the cycle after the write.
- FSM:
  - IDLE: on i_start, go to WAIT_PROMPT; o_busy=1; clear o_err_cnt, o_timeout; rptr=0. If count==0, go to FINISH instead.
  - WAIT_PROMPT: when a prompt is seen, go to ISSUE. If the wait counter reaches TIMEOUT_CYCLES, set o_timeout and go to FINISH.
  - ISSUE: one cycle. o_rdy=1; o_a/o_u = entry[rptr]; snapshot i_shop_a; rptr++. Go to WAIT_RESP.
  - WAIT_RESP: the first cycle where i_shop_a != snapshot, or SETTLE_CYCLES elapsed, ends the wait (change wins if both occur in the same cycle).
    - Load o_last_resp with i_shop_a.
    - If the word is an error, increment o_err_cnt, saturating.
    - If rptr==count, go to FINISH; otherwise go to WAIT_PROMPT.
  - FINISH: o_done=1 for one cycle; o_busy=0; rptr=0; script retained. Go to IDLE.
- o_a and o_u hold their last values outside ISSUE; o_rdy is 0 outside ISSUE.
- i_start outside IDLE is ignored.
- Script is cleared only by reset. A new replay reuses the same entries.
- Wait counter is cleared on every state entry.
- Reset mid-replay: immediate return to IDLE, o_rdy deasserted asynchronously, script lost.

Optional Feature:
- Macro: SHOP_CMD_DRIVER_STOP_ON_ERR_EN.
- Defined: an error response in WAIT_RESP sends the FSM to FINISH after counting; remaining entries are not issued, so o_err_cnt <= 1.
- Undefined: replay always runs to the end or to a timeout.

Test Plan:
- Load "Login" (u=0); start; shop model shows "Cmd?" -> after prompt, exactly one o_rdy pulse with o_a="Login"; shop switches to "Usrname?"; o_done pulses; o_err_cnt=0; o_last_resp="Usrname?".
- Load "AddItem", "Buy"; shop answers "ItmsFull" then "NoStock", showing "Cmd?" between them -> two issues, o_err_cnt=2, o_last_resp="NoStock". With the macro defined: one issue, o_err_cnt=1.
- Load 16 entries -> o_full=1; 17th write dropped; replay issues exactly 16 o_rdy pulses in order.
- Start with the shop holding "InvalCmd", never a prompt -> o_timeout=1 after 256 cycles; o_done pulses; zero o_rdy pulses.
- Shop keeps o_a="Cmd?" unchanged after an issue -> response accepted after SETTLE_CYCLES=4; next entry issued.
- Assert i_reset two cycles into WAIT_RESP -> all outputs 0 the same cycle; o_full=0; a following start with an empty script gives o_done within 2 cycles.

Source files
------------

// File: rtl/shop_cmd_driver.sv
// Replays a loaded script of shop tokens against the shop FSM, gating each issue on a prompt.
// Optional: SHOP_CMD_DRIVER_STOP_ON_ERR_EN ends the replay at the first error response.
module shop_cmd_driver #(
  parameter int I_A_NUM_BITS   = 56,
  parameter int O_A_NUM_BITS   = 72,
  parameter int I_U_NUM_BITS   = 4,
  parameter int SCRIPT_DEPTH   = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_wr_en,
  input  logic [I_A_NUM_BITS-1:0]               i_wr_tok,
  input  logic [I_U_NUM_BITS-1:0]               i_wr_u,
  output logic                                  o_full,
  input  logic                                  i_start,
  input  logic [O_A_NUM_BITS-1:0]               i_shop_a,
  output logic                                  o_rdy,
  output logic [I_A_NUM_BITS-1:0]               o_a,
  output logic [I_U_NUM_BITS-1:0]               o_u,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_timeout,
  output logic [$clog2(SCRIPT_DEPTH+1)-1:0]     o_err_cnt,
  output logic [O_A_NUM_BITS-1:0]               o_last_resp
);

  localparam int CW = $clog2(SCRIPT_DEPTH + 1);
  localparam int PW = $clog2(SCRIPT_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [O_A_NUM_BITS-1:0] RESP_USR_DEL = "UsrDeletd";
  localparam logic [O_A_NUM_BITS-1:0] RESP_ITM_ADD = {8'h00, "ItmAdded"};
  localparam logic [O_A_NUM_BITS-1:0] RESP_ITM_DEL = "ItmDeletd";
  localparam logic [O_A_NUM_BITS-1:0] RESP_ITM_BUY = "ItmBought";

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PROMPT, S_ISSUE, S_WAIT_RESP, S_FINISH
  } state_t;

  state_t state, state_n;

  logic [I_A_NUM_BITS-1:0] tok_mem [SCRIPT_DEPTH];
  logic [I_U_NUM_BITS-1:0] u_mem   [SCRIPT_DEPTH];
  logic [CW-1:0]           count;
  logic [CW-1:0]           rptr;
  logic [WW-1:0]           wcnt;
  logic [O_A_NUM_BITS-1:0] snap;

  logic is_prompt, is_success, is_error;
  logic wr_ok, start_ok, resp_end, timeout_hit;

  always_comb begin
    is_prompt   = (i_shop_a[7:0] == 8'h3F);
    is_success  = (i_shop_a == RESP_USR_DEL) || (i_shop_a == RESP_ITM_ADD) ||
                  (i_shop_a == RESP_ITM_DEL) || (i_shop_a == RESP_ITM_BUY);
    is_error    = (i_shop_a != '0) && !is_prompt && !is_success;
    wr_ok       = i_wr_en && (state == S_IDLE) && (count != CW'(SCRIPT_DEPTH));
    start_ok    = i_start && (state == S_IDLE);
    // A changed word wins over the settle limit; both end the wait the same way.
    resp_end    = (state == S_WAIT_RESP) &&
                  ((i_shop_a != snap) || (wcnt == WW'(SETTLE_CYCLES - 1)));
    timeout_hit = (state == S_WAIT_PROMPT) && !is_prompt &&
                  (wcnt == WW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    o_rdy   = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_n = (count == '0) ? S_FINISH : S_WAIT_PROMPT;
      end
      S_WAIT_PROMPT: begin
        o_busy = 1'b1;
        if (is_prompt)        state_n = S_ISSUE;
        else if (timeout_hit) state_n = S_FINISH;
      end
      S_ISSUE: begin
        o_busy  = 1'b1;
        o_rdy   = 1'b1;
        state_n = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        o_busy = 1'b1;
        if (resp_end) begin
          state_n = (rptr == count) ? S_FINISH : S_WAIT_PROMPT;
`ifdef SHOP_CMD_DRIVER_STOP_ON_ERR_EN
          if (is_error) state_n = S_FINISH;
`endif
        end
      end
      S_FINISH: begin
        o_done  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Script storage needs no reset: count gates every read.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      tok_mem[count[PW-1:0]] <= i_wr_tok;
      u_mem[count[PW-1:0]]   <= i_wr_u;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count       <= '0;
      o_full      <= 1'b0;
      rptr        <= '0;
      wcnt        <= '0;
      snap        <= '0;
      o_a         <= '0;
      o_u         <= '0;
      o_timeout   <= 1'b0;
      o_err_cnt   <= '0;
      o_last_resp <= '0;
    end else begin
      if (wr_ok) begin
        count  <= count + CW'(1);
        o_full <= ((count + CW'(1)) == CW'(SCRIPT_DEPTH));
      end
      wcnt <= (state_n != state) ? '0 : wcnt + WW'(1);
      if (start_ok) begin
        rptr      <= '0;
        o_err_cnt <= '0;
        o_timeout <= 1'b0;
      end
      if (state == S_WAIT_PROMPT && is_prompt) begin
        o_a <= tok_mem[rptr[PW-1:0]];
        o_u <= u_mem[rptr[PW-1:0]];
      end
      if (state == S_ISSUE) begin
        snap <= i_shop_a;
        rptr <= rptr + CW'(1);
      end
      if (timeout_hit) o_timeout <= 1'b1;
      if (resp_end) begin
        o_last_resp <= i_shop_a;
        if (is_error && (o_err_cnt != {CW{1'b1}})) o_err_cnt <= o_err_cnt + CW'(1);
      end
      if (state == S_FINISH) rptr <= '0;
    end
  end

endmodule
